// File: rtl/hps_led_pkg.sv
// Shared types and constants for the HPS board-LED status driver.
package hps_led_pkg;

    typedef enum logic [1:0] {
        MODE_BOOT  = 2'd0,
        MODE_RUN   = 2'd1,
        MODE_FAULT = 2'd2
    } mode_e;

    localparam int NUM_LEDS = 4;

    // Full-scale brightness for a PWM counter of the given width.
    function automatic int pwm_max(input int bits);
        return (1 << bits) - 1;
    endfunction

    // Counter width able to hold 0 .. n-1, never narrower than one bit.
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/hps_led_pwm_channel.sv
// One LED fade channel: brightness ramps toward its on/off target on each fade
// strobe and is compared against the shared PWM counter.
module hps_led_pwm_channel
    import hps_led_pkg::*;
#(
    parameter int PWM_BITS = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                fade_strobe,
    input  logic                target_on,
    input  logic                clear,
    input  logic [PWM_BITS-1:0] pwm_cnt,
    output logic [PWM_BITS-1:0] brightness,
    output logic                lit
);

    localparam logic [PWM_BITS-1:0] MAX = PWM_BITS'(pwm_max(PWM_BITS));

    // NOTE: state registers use non-blocking (<=) so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            brightness <= '0;
        end else if (clear) begin
            brightness <= '0;
        end else if (fade_strobe) begin
            if (target_on && brightness != MAX) begin
                brightness <= brightness + PWM_BITS'(1);
            end else if (!target_on && brightness != '0) begin
                brightness <= brightness - PWM_BITS'(1);
            end
        end
    end

    // Raw duty compare; the pwm_cnt == MAX slot is never lit here, so the caller
    // forces full scale on from brightness.
    assign lit = (pwm_cnt < brightness);

endmodule

// File: rtl/hps_led_status_driver.sv
// Board-LED driver behind the HPS subsystem: boot chase, PWM fade in run,
// latched unison blink after a watchdog reset.
module hps_led_status_driver
    import hps_led_pkg::*;
#(
    parameter int PWM_BITS       = 8,
    parameter int FADE_DIV       = 390625,
    parameter int CHASE_CYCLES   = 12500000,
    parameter int BLINK_CYCLES   = 25000000,
    parameter int LED_ACTIVE_LOW = 1
) (
    input  logic                clk_100_clk,
    input  logic                reset_reset_n,
    input  logic [NUM_LEDS-1:0] led_pio_in,
    input  logic                h2f_reset,
    input  logic                wd_reset_n,
    input  logic                ninit_done,
    output logic [NUM_LEDS-1:0] led_out,
    output logic [1:0]          led_mode,
    output logic [7:0]          wd_fault_count
);

    localparam int FADE_W  = cnt_width(FADE_DIV);
    localparam int CHASE_W = cnt_width(CHASE_CYCLES);
    localparam int BLINK_W = cnt_width(BLINK_CYCLES);
    localparam int IDX_W   = $clog2(NUM_LEDS);
    localparam logic [PWM_BITS-1:0] MAX     = PWM_BITS'(pwm_max(PWM_BITS));
    localparam logic [NUM_LEDS-1:0] LED_OFF = (LED_ACTIVE_LOW != 0) ? '1 : '0;

    mode_e                mode, mode_next;
    logic                 enter_fault;
    logic [PWM_BITS-1:0]  pwm_cnt;
    logic [FADE_W-1:0]    fade_cnt;
    logic                 fade_strobe;
    logic [CHASE_W-1:0]   chase_cnt;
    logic [IDX_W-1:0]     chase_idx;
    logic [BLINK_W-1:0]   blink_cnt;
    logic                 blink_on;
    logic [NUM_LEDS-1:0]  ch_lit, run_lit, lit_vec;
    logic [PWM_BITS-1:0]  brightness [NUM_LEDS];

    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        mode_next   = mode;
        enter_fault = 1'b0;
        if (!wd_reset_n) begin
            mode_next   = MODE_FAULT;
            enter_fault = (mode != MODE_FAULT);
        end else if (mode == MODE_FAULT) begin
            if (h2f_reset) mode_next = MODE_BOOT;
        end else begin
            mode_next = (ninit_done || h2f_reset) ? MODE_BOOT : MODE_RUN;
        end
    end

    always_ff @(posedge clk_100_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            mode           <= MODE_BOOT;
            wd_fault_count <= '0;
            pwm_cnt        <= '0;
            fade_cnt       <= '0;
        end else begin
            mode     <= mode_next;
            pwm_cnt  <= pwm_cnt + PWM_BITS'(1);
            fade_cnt <= fade_strobe ? '0 : fade_cnt + FADE_W'(1);
            if (enter_fault && wd_fault_count != 8'hFF) begin
                wd_fault_count <= wd_fault_count + 8'd1;
            end
        end
    end

    assign fade_strobe = (fade_cnt == FADE_W'(FADE_DIV - 1));
    assign led_mode    = mode;

    // Chase and blink prescalers sit at zero outside their mode, so each entry restarts them.
    always_ff @(posedge clk_100_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            chase_cnt <= '0;
            chase_idx <= '0;
            blink_cnt <= '0;
            blink_on  <= 1'b1;
        end else begin
            if (mode != MODE_BOOT) begin
                chase_cnt <= '0;
                chase_idx <= '0;
            end else if (chase_cnt == CHASE_W'(CHASE_CYCLES - 1)) begin
                chase_cnt <= '0;
                chase_idx <= chase_idx + IDX_W'(1);
            end else begin
                chase_cnt <= chase_cnt + CHASE_W'(1);
            end

            if (mode != MODE_FAULT) begin
                blink_cnt <= '0;
                blink_on  <= 1'b1;
            end else if (blink_cnt == BLINK_W'(BLINK_CYCLES - 1)) begin
                blink_cnt <= '0;
                blink_on  <= ~blink_on;
            end else begin
                blink_cnt <= blink_cnt + BLINK_W'(1);
            end
        end
    end

    for (genvar i = 0; i < NUM_LEDS; i++) begin : g_ch
        hps_led_pwm_channel #(.PWM_BITS(PWM_BITS)) u_ch (
            .clk         (clk_100_clk),
            .rst_n       (reset_reset_n),
            .fade_strobe (fade_strobe && mode == MODE_RUN),
            .target_on   (led_pio_in[i]),
            .clear       (mode == MODE_BOOT),
            .pwm_cnt     (pwm_cnt),
            .brightness  (brightness[i]),
            .lit         (ch_lit[i])
        );
        assign run_lit[i] = ch_lit[i] || (brightness[i] == MAX);
    end

    always_comb begin
        lit_vec = '0;
        unique case (mode)
            MODE_BOOT:  lit_vec = NUM_LEDS'(1) << chase_idx;
            MODE_RUN:   lit_vec = run_lit;
            MODE_FAULT: lit_vec = {NUM_LEDS{blink_on}};
            default:    lit_vec = '0;
        endcase
    end

    always_ff @(posedge clk_100_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            led_out <= LED_OFF;
        end else begin
            led_out <= (LED_ACTIVE_LOW != 0) ? ~lit_vec : lit_vec;
        end
    end

endmodule

// File: tb/tb_hps_led_status_driver.sv
// Scoreboard bench for hps_led_status_driver with small prescalers.
module tb_hps_led_status_driver;

    logic       clk_100_clk = 1'b0;
    logic       reset_reset_n;
    logic [3:0] led_pio_in;
    logic       h2f_reset;
    logic       wd_reset_n;
    logic       ninit_done;
    logic [3:0] led_out;
    logic [1:0] led_mode;
    logic [7:0] wd_fault_count;

    hps_led_status_driver #(
        .PWM_BITS       (4),
        .FADE_DIV       (2),
        .CHASE_CYCLES   (8),
        .BLINK_CYCLES   (4),
        .LED_ACTIVE_LOW (1)
    ) dut (
        .clk_100_clk    (clk_100_clk),
        .reset_reset_n  (reset_reset_n),
        .led_pio_in     (led_pio_in),
        .h2f_reset      (h2f_reset),
        .wd_reset_n     (wd_reset_n),
        .ninit_done     (ninit_done),
        .led_out        (led_out),
        .led_mode       (led_mode),
        .wd_fault_count (wd_fault_count)
    );

    always #5 clk_100_clk = ~clk_100_clk;

    typedef enum int {K_OUT, K_MODE, K_CNT} kind_e;
    typedef struct {
        string      tag;
        kind_e      kind;
        int         due;
        logic [7:0] val;
    } exp_t;

    exp_t sb[$];
    int   cyc = 0;
    int   c0 = 0;
    int   n_checks = 0;
    int   n_pass = 0;
    logic [3:0] chase_pat [5] = '{4'hE, 4'hD, 4'hB, 4'h7, 4'hE};

    always @(posedge clk_100_clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [7:0] actual, input logic [7:0] expected);
        n_checks++;
        if (actual === expected) n_pass++;
        else $display("FAIL %s: got %h, want %h (cycle %0d)", tag, actual, expected, cyc);
    endtask

    function automatic logic [7:0] observe(input kind_e k);
        case (k)
            K_OUT:   return {4'h0, led_out};
            K_MODE:  return {6'h0, led_mode};
            default: return wd_fault_count;
        endcase
    endfunction

    task automatic expect_at(input int due, input kind_e k, input logic [7:0] v, input string tag);
        exp_t e;
        e.tag  = tag;
        e.kind = k;
        e.due  = due;
        e.val  = v;
        sb.push_back(e);
    endtask

    // Pop every expectation that has come due; outputs are stable at the falling edge.
    always @(negedge clk_100_clk) begin
        for (int i = sb.size() - 1; i >= 0; i--) begin
            if (sb[i].due <= cyc) begin
                check(sb[i].tag, observe(sb[i].kind), sb[i].val);
                sb.delete(i);
            end
        end
    end

    task automatic goto(input int rel);
        while (cyc < c0 + rel) @(negedge clk_100_clk);
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: bench did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int a;
        int exp_cnt;
        reset_reset_n = 1'b0;
        ninit_done    = 1'b1;
        h2f_reset     = 1'b0;
        wd_reset_n    = 1'b1;
        led_pio_in    = 4'h0;
        repeat (3) @(negedge clk_100_clk);
        check("rst_led_out", {4'h0, led_out}, 8'h0F);
        check("rst_mode", {6'h0, led_mode}, 8'h00);
        check("rst_count", wd_fault_count, 8'h00);

        @(negedge clk_100_clk);
        reset_reset_n = 1'b1;
        c0 = cyc;
        expect_at(c0 + 1, K_MODE, 8'd0, "boot_mode");
        for (int k = 0; k < 40; k++) expect_at(c0 + 1 + k, K_OUT, {4'h0, chase_pat[k / 8]}, "boot_chase");

        goto(40);
        ninit_done = 1'b0;
        led_pio_in = 4'h1;
        expect_at(c0 + 41, K_MODE, 8'd1, "run_mode");
        expect_at(c0 + 42, K_OUT, 8'h0F, "run_starts_dark");
        for (int r = 71; r <= 86; r++) expect_at(c0 + r, K_OUT, 8'h0E, "fade_up_full");

        goto(96);
        ninit_done = 1'b1;
        expect_at(c0 + 97, K_MODE, 8'd0, "reboot_mode");
        expect_at(c0 + 98, K_OUT, 8'h0E, "reboot_chase0");

        goto(98);
        ninit_done = 1'b0;
        expect_at(c0 + 99, K_MODE, 8'd1, "rerun_mode");
        expect_at(c0 + 100, K_OUT, 8'h0F, "rerun_dark");

        goto(114);
        led_pio_in = 4'h0;
        for (int j = 19; j <= 40; j++)
            expect_at(c0 + 96 + j, K_OUT, (j <= 22 || j == 33) ? 8'h0E : 8'h0F, "fade_down");

        goto(140);
        wd_reset_n = 1'b0;
        expect_at(c0 + 141, K_MODE, 8'd2, "fault_mode");
        expect_at(c0 + 141, K_CNT, 8'd1, "fault_count");
        for (int r = 142; r <= 153; r++)
            expect_at(c0 + r, K_OUT, (((r - 142) / 4) % 2 == 0) ? 8'h00 : 8'h0F, "fault_blink");
        goto(141);
        wd_reset_n = 1'b1;

        goto(156);
        wd_reset_n = 1'b0;
        expect_at(c0 + 160, K_CNT, 8'd1, "wd_hold_count");
        goto(166);
        wd_reset_n = 1'b1;
        expect_at(c0 + 167, K_CNT, 8'd1, "wd_hold_count_end");
        expect_at(c0 + 167, K_MODE, 8'd2, "fault_latched");

        goto(170);
        wd_reset_n = 1'b0;
        h2f_reset  = 1'b1;
        expect_at(c0 + 171, K_MODE, 8'd2, "h2f_with_wd_low");
        expect_at(c0 + 171, K_CNT, 8'd1, "no_reentry_count");
        expect_at(c0 + 172, K_MODE, 8'd2, "still_fault");
        goto(171);
        h2f_reset  = 1'b0;
        wd_reset_n = 1'b1;

        goto(174);
        h2f_reset  = 1'b1;
        ninit_done = 1'b1;
        expect_at(c0 + 175, K_MODE, 8'd0, "recover_boot");
        expect_at(c0 + 176, K_OUT, 8'h0E, "recover_chase_first");
        expect_at(c0 + 183, K_OUT, 8'h0E, "recover_chase_hold");
        expect_at(c0 + 184, K_OUT, 8'h0D, "recover_chase_step");
        expect_at(c0 + 176, K_CNT, 8'd1, "recover_count");
        goto(175);
        h2f_reset = 1'b0;

        goto(190);
        for (int i = 0; i < 256; i++) begin
            wd_reset_n = 1'b0;
            exp_cnt = (i + 2 > 255) ? 255 : i + 2;
            expect_at(cyc + 1, K_CNT, 8'(exp_cnt), "wd_count_sat");
            @(negedge clk_100_clk);
            wd_reset_n = 1'b1;
            h2f_reset  = 1'b1;
            @(negedge clk_100_clk);
            h2f_reset = 1'b0;
            @(negedge clk_100_clk);
        end

        a = cyc;
        wd_reset_n = 1'b0;
        expect_at(a + 1, K_CNT, 8'd255, "sat_reentry");
        expect_at(a + 1, K_MODE, 8'd2, "sat_fault_mode");
        expect_at(a + 2, K_OUT, 8'h00, "blink_on_a");
        expect_at(a + 3, K_OUT, 8'h00, "blink_on_b");
        @(negedge clk_100_clk);
        wd_reset_n = 1'b1;
        @(negedge clk_100_clk);
        @(negedge clk_100_clk);
        #1;
        reset_reset_n = 1'b0;
        #1;
        check("async_rst_led_out", {4'h0, led_out}, 8'h0F);
        check("async_rst_count", wd_fault_count, 8'h00);
        check("async_rst_mode", {6'h0, led_mode}, 8'h00);
        repeat (2) @(negedge clk_100_clk);
        reset_reset_n = 1'b1;
        repeat (3) @(negedge clk_100_clk);
        check("sb_drain", 8'(sb.size()), 8'h00);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
